// File: rtl/gpio_scan_ctrl.sv
// Row/digit scan multiplexer with anti-ghost blanking, plus a once-per-frame
// switch read on the shared LED/switch bus with a consecutive-sample debouncer.
module gpio_scan_ctrl #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 16,
  parameter int unsigned SEG_W        = 8,
  parameter int unsigned IO_W         = 32,
  parameter int unsigned ROW_CYCLES   = 16384,
  parameter int unsigned BLANK_CYCLES = 2048,
  parameter int unsigned FLOAT_CYCLES = 128,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned REV_COLS     = 1,
  parameter int unsigned REV_IO       = 1
) (
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic [ROWS*COLS-1:0]     row_data,
  input  logic [ROWS*SEG_W-1:0]    seg_data,
  input  logic [IO_W-1:0]          leds,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_out,
  output logic [SEG_W-1:0]         seg_out,
  output logic [IO_W-1:0]          io_out,
  output logic                     io_oe,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          dip_sw,
  output logic                     dip_valid,
  output logic                     dip_changed,
  output logic [$clog2(ROWS)-1:0]  row_idx
);

  localparam int unsigned SLOT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned FLT_W  = (FLOAT_CYCLES > 1) ? $clog2(FLOAT_CYCLES) : 1;
  localparam int unsigned STB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [SLOT_W-1:0] SlotLast = SLOT_W'(ROW_CYCLES - 1);
  localparam logic [SLOT_W-1:0] BlankLo  = SLOT_W'(BLANK_CYCLES);
  localparam logic [SLOT_W-1:0] BlankHi  = SLOT_W'(ROW_CYCLES - BLANK_CYCLES);
  localparam logic [ROW_W-1:0]  RowLast  = ROW_W'(ROWS - 1);
  localparam logic [FLT_W-1:0]  FltLast  = FLT_W'(FLOAT_CYCLES - 1);
  localparam logic [STB_W-1:0]  StbLast  = STB_W'(DEBOUNCE - 1);

  typedef enum logic {StDrive, StFloat} state_e;

  logic [SLOT_W-1:0] slot_cnt_q;
  logic [ROW_W-1:0]  row_idx_q;
  logic              slot_wrap;
  logic [31:0]       row_i;
  logic [COLS-1:0]   row_slice, col_d;
  logic [SEG_W-1:0]  seg_d;
  logic [ROWS-1:0]   row_sel_d;
  logic              blank;

  // Scan counters
  assign slot_wrap = (slot_cnt_q == SlotLast);

  always_ff @(posedge clock_50) begin
    if (reset) begin
      slot_cnt_q <= '0;
      row_idx_q  <= '0;
    end else begin
      slot_cnt_q <= slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
      if (slot_wrap) begin
        row_idx_q <= (row_idx_q == RowLast) ? '0 : row_idx_q + ROW_W'(1);
      end
    end
  end

  always_comb begin
    row_i     = 32'(row_idx_q);
    row_slice = row_data[row_i*COLS +: COLS];
    seg_d     = seg_data[row_i*SEG_W +: SEG_W];
    col_d     = row_slice;
    if (REV_COLS != 0) begin
      for (int i = 0; i < int'(COLS); i++) col_d[i] = row_slice[COLS-1-i];
    end
    // Dark guard bands at both slot ends stop the previous row ghosting.
    blank     = (slot_cnt_q < BlankLo) || (slot_cnt_q >= BlankHi);
    row_sel_d = blank ? '0 : (ROWS'(1) << row_idx_q);
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      row_sel <= '0;
      col_out <= '0;
      seg_out <= '0;
    end else begin
      row_sel <= row_sel_d;
      col_out <= col_d;
      seg_out <= seg_d;
    end
  end

  assign row_idx = row_idx_q;

  // Switch-read FSM
  state_e           state_q, state_d;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             flt_last, capture, drive_d;
  logic [IO_W-1:0]  leds_rev, sample;

  assign flt_last = (flt_cnt_q == FltLast);

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q   <= StDrive;
      flt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      flt_cnt_q <= (state_q == StFloat && !flt_last) ? flt_cnt_q + FLT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDrive: if (row_idx_q == '0 && slot_cnt_q == '0) state_d = StFloat;
      StFloat: if (flt_last) state_d = StDrive;
      default: state_d = StDrive;
    endcase
  end

  always_comb begin
    drive_d  = (state_d == StDrive);
    capture  = (state_q == StFloat) && flt_last;
    leds_rev = leds;
    sample   = io_in;
    if (REV_IO != 0) begin
      for (int i = 0; i < int'(IO_W); i++) begin
        leds_rev[i] = leds[IO_W-1-i];
        sample[i]   = io_in[IO_W-1-i];
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      io_oe  <= 1'b0;
      io_out <= '0;
    end else begin
      io_oe <= drive_d;
      if (drive_d) io_out <= leds_rev;
    end
  end

  // Debouncer
  logic [IO_W-1:0]  prev_q, dip_sw_q;
  logic             prev_valid_q, dip_valid_q, dip_changed_q, take;
  logic [STB_W-1:0] stable_q, stable_d;

  always_comb begin
    stable_d = '0;
    if (prev_valid_q && sample == prev_q) begin
      stable_d = (stable_q == StbLast) ? stable_q : stable_q + STB_W'(1);
    end
    take = capture && (stable_d == StbLast) && (sample != dip_sw_q);
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      stable_q      <= '0;
      dip_sw_q      <= '0;
      dip_valid_q   <= 1'b0;
      dip_changed_q <= 1'b0;
    end else begin
      dip_valid_q   <= capture;
      dip_changed_q <= take;
      if (capture) begin
        prev_q       <= sample;
        prev_valid_q <= 1'b1;
        stable_q     <= stable_d;
      end
      if (take) dip_sw_q <= sample;
    end
  end

  assign dip_sw      = dip_sw_q;
  assign dip_valid   = dip_valid_q;
  assign dip_changed = dip_changed_q;

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// Self-checking bench for gpio_scan_ctrl: scan timing, switch float windows
// and debouncing compared against a cycle-indexed behavioural model.
module tb_gpio_scan_ctrl;

  localparam int ROWS = 4, COLS = 4, SEG_W = 8, IO_W = 8;
  localparam int RC = 16, BLANK = 2, FLT = 4, DEB = 3;
  localparam int FRAME = ROWS * RC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] row_data = 16'h8421;
  logic [31:0] seg_data = 32'h13121110;
  logic [7:0]  leds = 8'h12;
  logic [7:0]  io_in = 8'h00;
  logic [3:0]  row_sel, col_out;
  logic [7:0]  seg_out, io_out, dip_sw;
  logic        io_oe, dip_valid, dip_changed;
  logic [1:0]  row_idx;

  gpio_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SEG_W(SEG_W), .IO_W(IO_W), .ROW_CYCLES(RC),
    .BLANK_CYCLES(BLANK), .FLOAT_CYCLES(FLT), .DEBOUNCE(DEB), .REV_COLS(1), .REV_IO(1)
  ) dut (
    .clock_50(clk), .reset(reset), .row_data(row_data), .seg_data(seg_data), .leds(leds),
    .row_sel(row_sel), .col_out(col_out), .seg_out(seg_out), .io_out(io_out), .io_oe(io_oe),
    .io_in(io_in), .dip_sw(dip_sw), .dip_valid(dip_valid), .dip_changed(dip_changed),
    .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cyc counts clock edges since reset was last sampled high.
  int         cyc = 0;
  logic [7:0] hist[$];
  logic [7:0] m_dip = 8'h00, m_io_out = 8'h00, m_seg = 8'h00;
  logic [3:0] m_col = 4'h0;
  bit         m_valid = 0, m_changed = 0;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  // Bus is released for the first FLT edges of every frame after reset.
  function automatic bit exp_oe(input int c);
    return (c >= 1) && (((c - 1) % FRAME) >= FLT);
  endfunction

  function automatic logic [3:0] exp_row_sel(input int c);
    int p, slot, row;
    if (c == 0) return 4'h0;
    p    = c - 1;
    slot = p % RC;
    row  = (p / RC) % ROWS;
    if (slot < BLANK || slot >= RC - BLANK) return 4'h0;
    return 4'(1 << row);
  endfunction

  function automatic logic [1:0] exp_row_idx(input int c);
    return 2'((c / RC) % ROWS);
  endfunction

  task automatic tick();
    logic [7:0] s;
    bit         same;
    int         row;
    @(posedge clk);
    m_valid   = 0;
    m_changed = 0;
    if (reset) begin
      cyc = 0;
      hist.delete();
      m_dip    = 8'h00;
      m_io_out = 8'h00;
      m_col    = 4'h0;
      m_seg    = 8'h00;
    end else begin
      cyc++;
      row   = ((cyc - 1) / RC) % ROWS;
      m_col = rev4(row_data[row*COLS +: COLS]);
      m_seg = seg_data[row*SEG_W +: SEG_W];
      if (exp_oe(cyc)) m_io_out = rev8(leds);
      if (((cyc - 1) % FRAME) == FLT) begin
        s = rev8(io_in);
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_valid = 1;
        // Update only once DEB consecutive identical samples have been seen.
        same = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != s) same = 0;
        if (same && s != m_dip) begin
          m_dip     = s;
          m_changed = 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++; if (row_sel !== 4'h0) begin n_fail++; $display("FAIL reset_row_sel: got %h want 0", row_sel); end
    n_tests++; if (io_oe !== 1'b0) begin n_fail++; $display("FAIL reset_io_oe: got %b want 0", io_oe); end
    n_tests++; if (dip_sw !== 8'h00) begin n_fail++; $display("FAIL reset_dip_sw: got %h want 0", dip_sw); end
    n_tests++; if (dip_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dip_valid: got %b want 0", dip_valid); end
    n_tests++; if (row_idx !== 2'd0) begin n_fail++; $display("FAIL reset_row_idx: got %0d want 0", row_idx); end
    reset = 1'b0;
    for (int i = 0; i < FLT; i++) begin
      tick();
      n_tests++; if (io_oe !== 1'b0) begin n_fail++; $display("FAIL release_float_oe: cyc %0d got %b want 0", cyc, io_oe); end
    end
    tick();
    n_tests++; if (io_oe !== 1'b1) begin n_fail++; $display("FAIL release_drive_oe: got %b want 1", io_oe); end
    n_tests++; if (io_out !== 8'h48) begin n_fail++; $display("FAIL release_io_out: got %h want 48", io_out); end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      if (i >= FRAME + 5) begin
        row_data = 16'($urandom);
        seg_data = $urandom;
        leds     = 8'($urandom);
      end
      tick();
      n_tests++; if (row_sel !== exp_row_sel(cyc)) begin n_fail++; $display("FAIL scan_row_sel: cyc %0d got %h want %h", cyc, row_sel, exp_row_sel(cyc)); end
      n_tests++; if (row_idx !== exp_row_idx(cyc)) begin n_fail++; $display("FAIL scan_row_idx: cyc %0d got %0d want %0d", cyc, row_idx, exp_row_idx(cyc)); end
      n_tests++; if (col_out !== m_col) begin n_fail++; $display("FAIL scan_col_out: cyc %0d got %h want %h", cyc, col_out, m_col); end
      n_tests++; if (seg_out !== m_seg) begin n_fail++; $display("FAIL scan_seg_out: cyc %0d got %h want %h", cyc, seg_out, m_seg); end
      n_tests++; if (io_oe !== exp_oe(cyc)) begin n_fail++; $display("FAIL scan_io_oe: cyc %0d got %b want %b", cyc, io_oe, exp_oe(cyc)); end
      n_tests++; if (io_out !== m_io_out) begin n_fail++; $display("FAIL scan_io_out: cyc %0d got %h want %h", cyc, io_out, m_io_out); end
      n_tests++; if (dip_valid !== m_valid) begin n_fail++; $display("FAIL scan_dip_valid: cyc %0d got %b want %b", cyc, dip_valid, m_valid); end
    end
    row_data = 16'h8421;
    seg_data = 32'h13121110;
  endtask

  task automatic test_toggle();
    int changes = 0;
    for (int f = 0; f < 9; f++) begin
      io_in = (f < 6 && f % 2 == 0) ? 8'h01 : 8'h00;
      repeat (FRAME) begin
        tick();
        if (dip_changed === 1'b1) changes++;
        n_tests++; if (dip_sw !== m_dip) begin n_fail++; $display("FAIL toggle_dip_sw: cyc %0d got %h want %h", cyc, dip_sw, m_dip); end
        n_tests++; if (dip_changed !== m_changed) begin n_fail++; $display("FAIL toggle_changed: cyc %0d got %b want %b", cyc, dip_changed, m_changed); end
      end
    end
    n_tests++; if (changes != 0) begin n_fail++; $display("FAIL toggle_change_count: got %0d want 0", changes); end
    n_tests++; if (dip_sw !== 8'h00) begin n_fail++; $display("FAIL toggle_final: got %h want 00", dip_sw); end
  endtask

  task automatic test_constant();
    int changes = 0, samples = 0, change_at = 0;
    io_in = 8'h01;
    repeat (4 * FRAME) begin
      tick();
      if (dip_valid === 1'b1) samples++;
      if (dip_changed === 1'b1) begin
        changes++;
        change_at = samples;
      end
      n_tests++; if (dip_valid !== m_valid) begin n_fail++; $display("FAIL const_dip_valid: cyc %0d got %b want %b", cyc, dip_valid, m_valid); end
      n_tests++; if (dip_sw !== m_dip) begin n_fail++; $display("FAIL const_dip_sw: cyc %0d got %h want %h", cyc, dip_sw, m_dip); end
    end
    n_tests++; if (samples != 4) begin n_fail++; $display("FAIL const_sample_count: got %0d want 4", samples); end
    n_tests++; if (changes != 1) begin n_fail++; $display("FAIL const_change_count: got %0d want 1", changes); end
    n_tests++; if (change_at != 3) begin n_fail++; $display("FAIL const_change_sample: got %0d want 3", change_at); end
    n_tests++; if (dip_sw !== 8'h80) begin n_fail++; $display("FAIL const_dip_sw_final: got %h want 80", dip_sw); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 41; i++) tick();
    n_tests++; if (row_idx !== 2'd2) begin n_fail++; $display("FAIL mid_pre_row: got %0d want 2", row_idx); end
    n_tests++; if (dip_sw !== 8'h80) begin n_fail++; $display("FAIL mid_pre_dip_sw: got %h want 80", dip_sw); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (dip_sw !== 8'h00) begin n_fail++; $display("FAIL mid_dip_sw: got %h want 00", dip_sw); end
    n_tests++; if (row_idx !== 2'd0) begin n_fail++; $display("FAIL mid_row_idx: got %0d want 0", row_idx); end
    n_tests++; if (row_sel !== 4'h0) begin n_fail++; $display("FAIL mid_row_sel: got %h want 0", row_sel); end
    n_tests++; if (io_oe !== 1'b0) begin n_fail++; $display("FAIL mid_io_oe: got %b want 0", io_oe); end
    for (int i = 0; i < FLT; i++) begin
      tick();
      n_tests++; if (io_oe !== 1'b0) begin n_fail++; $display("FAIL mid_float_oe: cyc %0d got %b want 0", cyc, io_oe); end
    end
    tick();
    n_tests++; if (io_oe !== 1'b1) begin n_fail++; $display("FAIL mid_drive_oe: got %b want 1", io_oe); end
    n_tests++; if (dip_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_valid: got %b want 1", dip_valid); end
    n_tests++; if (dip_sw !== 8'h00) begin n_fail++; $display("FAIL mid_first_sample: got %h want 00", dip_sw); end
  endtask

  task automatic test_leds();
    for (int i = 0; i < FRAME && !exp_oe(cyc + 1); i++) tick();
    leds = 8'hA5;
    tick();
    n_tests++; if (io_out !== 8'hA5) begin n_fail++; $display("FAIL leds_a5: got %h want a5", io_out); end
    leds = 8'h0F;
    tick();
    n_tests++; if (io_out !== 8'hF0) begin n_fail++; $display("FAIL leds_0f: got %h want f0", io_out); end
    for (int i = 0; i < FRAME && exp_oe(cyc); i++) tick();
    for (int i = 0; i < FLT - 1; i++) begin
      leds = 8'($urandom);
      tick();
      n_tests++; if (io_oe !== 1'b0) begin n_fail++; $display("FAIL leds_float_oe: got %b want 0", io_oe); end
      n_tests++; if (io_out !== 8'hF0) begin n_fail++; $display("FAIL leds_float_hold: got %h want f0", io_out); end
    end
    tick();
    n_tests++; if (io_out !== rev8(leds)) begin n_fail++; $display("FAIL leds_resume: got %h want %h", io_out, rev8(leds)); end
  endtask

  task automatic test_random_switch();
    logic [7:0] choices [4] = '{8'h00, 8'h01, 8'h80, 8'h5A};
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 2) == 0) io_in = choices[$urandom_range(0, 3)];
      repeat (FRAME) begin
        if ($urandom_range(0, 7) == 0) leds = 8'($urandom);
        tick();
        n_tests++; if (dip_sw !== m_dip) begin n_fail++; $display("FAIL rand_dip_sw: cyc %0d got %h want %h", cyc, dip_sw, m_dip); end
        n_tests++; if (dip_changed !== m_changed) begin n_fail++; $display("FAIL rand_changed: cyc %0d got %b want %b", cyc, dip_changed, m_changed); end
        n_tests++; if (dip_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, dip_valid, m_valid); end
        n_tests++; if (io_out !== m_io_out) begin n_fail++; $display("FAIL rand_io_out: cyc %0d got %h want %h", cyc, io_out, m_io_out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_toggle();
    test_constant();
    test_reset_mid();
    test_leds();
    test_random_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_scan_ctrl.md
Name: gpio_scan_ctrl

Overview:
- Parametrised, resettable scan controller for GPIO display/IO boards.
- Time-multiplexes ROWS rows of matrix-column data and seven-segment (+DP) data onto a row-select/column/segment output bus, with anti-ghosting blanking.
- Periodically floats a shared LED/switch bus to sample switches, and debounces the sampled value.
- Sits between core logic and the board's GPIO headers. The top level builds the tristate from io_out/io_oe.

Parameters:
ROWS, 8, number of scanned rows / digits (>=2)
COLS, 16, matrix columns per row
SEG_W, 8, segment bits per digit (7 segments + DP)
IO_W, 32, shared LED/switch bus width
ROW_CYCLES, 16384, clocks per row slot
BLANK_CYCLES, 2048, blanked clocks at each end of a slot; 2*BLANK_CYCLES < ROW_CYCLES
FLOAT_CYCLES, 128, clocks io bus is released per switch read; FLOAT_CYCLES < ROW_CYCLES
DEBOUNCE, 3, consecutive identical samples needed to update dip_sw (>=1)
REV_COLS, 1, 1 = column bits reversed so LSb displays rightmost
REV_IO, 1, 1 = io bus bit order reversed for LEDs and switches

Ports:
clock_50  in  1  system clock
reset  in  1  synchronous, active-high reset
row_data  in  ROWS*COLS  row r occupies bits [r*COLS +: COLS]
seg_data  in  ROWS*SEG_W  digit r occupies bits [r*SEG_W +: SEG_W], {DP, seg[6:0]}
leds  in  IO_W  LED values to display
row_sel  out  ROWS  one-hot active row, 0 while blanked
col_out  out  COLS  columns of the active row
seg_out  out  SEG_W  segments of the active digit
io_out  out  IO_W  value driven onto the LED/switch bus
io_oe  out  1  1 = drive io_out, 0 = bus released
io_in  in  IO_W  bus readback (switches)
dip_sw  out  IO_W  debounced switch value
dip_valid  out  1  one-cycle pulse per raw sample
dip_changed  out  1  one-cycle pulse when dip_sw updates
row_idx  out  clog2(ROWS)  current scan row (debug/sync)

Behaviour:
- Reset (synchronous, active-high; dominates everything): slot_cnt=0, row_idx=0, row_sel=0, FSM=DRIVE, io_oe=0, io_out=0, dip_sw=0, stable count=0, dip_valid=0, dip_changed=0.
- Reset mid-operation: the next cycle after reset deasserts restarts at row 0, slot_cnt 0, and a float window begins (see below). No partial debounce state is retained.
- Scan counter: slot_cnt runs 0..ROW_CYCLES-1. At the wrap, row_idx increments, and wraps ROWS-1 -> 0. ROWS and ROW_CYCLES need not be powers of two.
- Outputs are registered: one clock latency from counter/inputs to row_sel/col_out/seg_out.
- col_out = row_data slice[row_idx], bit-reversed when REV_COLS=1.
- seg_out = seg_data slice[row_idx]. Both are always driven, including during blanking.
- row_sel = onehot(row_idx), except 0 when slot_cnt < BLANK_CYCLES or slot_cnt >= ROW_CYCLES-BLANK_CYCLES.
- Switch FSM, states DRIVE and FLOAT:
  - DRIVE: io_oe=1; io_out=leds (reversed when REV_IO=1), updated every clock. Moves to FLOAT when row_idx==0 and slot_cnt==0, i.e. once per frame.
  - FLOAT: io_oe=0; io_out keeps its last value. A float counter runs 0..FLOAT_CYCLES-1.
  - On float count FLOAT_CYCLES-1: capture io_in (reversed when REV_IO=1) into raw sample, pulse dip_valid the next cycle, return to DRIVE.
  - After reset the FSM enters FLOAT on the first cycle, since the counters are at 0.
- Debounce, evaluated on each raw sample:
  - If sample == previous sample, stable = min(stable+1, DEBOUNCE-1); else stable=0.
  - When stable reaches DEBOUNCE-1 and sample != dip_sw: dip_sw <= sample, and dip_changed pulses in the same cycle as dip_valid.
  - DEBOUNCE=1: every sample that differs updates immediately.
  - The first sample after reset counts as stable=0.
- leds/row_data changes take effect at the next clock; no glitch filtering.
- Simultaneous row wrap and float entry are independent; scanning never stalls during FLOAT.

Test Plan:
Use ROWS=4, COLS=4, SEG_W=8, IO_W=8, ROW_CYCLES=16, BLANK_CYCLES=2, FLOAT_CYCLES=4, DEBOUNCE=3.
1. Reset held 3 clocks -> row_sel=0, io_oe=0, dip_sw=0, dip_valid=0. Release -> io_oe stays 0 for 4 clocks, then 1 with io_out=bitrev(leds).
2. row_data={4'h8,4'h4,4'h2,4'h1}, seg_data digit r = 8'h10+r -> row 0: row_sel=4'b0001 on slot counts 2..13, 0 on 0,1,14,15, col_out=4'b1000, seg_out=8'h10. Row 3 follows after 48 clocks; row 0 returns after 64 clocks.
3. io_in=8'h01 constant -> dip_valid every 64 clocks; dip_sw=8'h80 (reversed) and dip_changed pulse on the 3rd sample only.
4. io_in toggles 8'h01/8'h00 every frame -> dip_sw never changes, dip_changed never pulses. Then hold 8'h00 for 3 frames -> still no change, since it equals dip_sw.
5. Reset asserted at row 2, slot_cnt 9, after dip_sw=8'h80 -> next cycle dip_sw=0, row_idx=0, row_sel=0. The float window restarts after release.
6. leds=8'hA5 in DRIVE -> io_out=8'hA5 (bit-reverse palindrome); leds=8'h0F -> io_out=8'hF0 next clock; unchanged while FLOAT.
